// File: rtl/prbg_ctrl_pkg.sv
// prbg_ctrl_pkg: state encoding and default sizing for the PRBG run controller
package prbg_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam int DEF_RUN_LEN  = 64;
    localparam int DEF_LOAD_CYC = 2;
    localparam int DEF_CNT_W    = 8;
endpackage

// File: rtl/prbg_rr_arb.sv
// prbg_rr_arb: 2-way round-robin arbiter; a tie goes to the requester that did not win last
module prbg_rr_arb (
    input  logic       clk,
    input  logic       res_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] win
);
    logic ptr;
    assign win = (req == 2'b11) ? (ptr ? 2'b01 : 2'b10) : req;
    // pointer records the last winner; starts at 1 so requester 0 takes the first tie
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) ptr <= 1'b1;
        else if (en && |req) ptr <= win[1];
endmodule

// File: rtl/prbg_run_ctrl.sv
// prbg_run_ctrl: arbitrates two requesters onto one PRBG detector datapath and reports hit counts per run
module prbg_run_ctrl
    import prbg_ctrl_pkg::*;
#(
    parameter int RUN_LEN  = DEF_RUN_LEN,
    parameter int LOAD_CYC = DEF_LOAD_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [1:0]       req,
    input  logic [7:0]       seed_a,
    input  logic [7:0]       seed_b,
    input  logic [1:0]       src_sel,
    input  logic             detect_in,
    output logic [3:0]       dp_a_in,
    output logic [3:0]       dp_b_in,
    output logic             dp_sel,
    output logic             dp_res,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             aborted,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] HIT_MAX   = '1;

    state_t           state, st_nx;
    logic [CNT_W-1:0] cnt, hit, hit_nx;
    logic [1:0]       win;
    logic             abort;

    assign abort  = ~|(req & grant);
    assign hit_nx = (state == ST_RUN && detect_in && hit != HIT_MAX) ? hit + 1'b1 : hit;

    prbg_rr_arb u_arb (
        .clk   (clk),
        .res_n (res_n),
        .req   (req),
        .en    (state == ST_IDLE),
        .win   (win)
    );

    // next state: abort from LOAD/RUN when the granted request drops, otherwise count out each phase
    always_comb begin
        st_nx = state;
        st_nx = (state == ST_IDLE) ? (|req ? ST_LOAD : ST_IDLE) :
                (state == ST_DONE) ? ST_IDLE :
                abort              ? ST_DONE :
                (state == ST_LOAD) ? ((cnt == LOAD_LAST) ? ST_RUN : ST_LOAD) :
                                     ((cnt == RUN_LAST) ? ST_DONE : ST_RUN);
    end

    // state register
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) state <= ST_IDLE;
        else state <= st_nx;

    // phase cycle counter restarts on every state change; hit counter restarts at grant
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            cnt <= '0;
            hit <= '0;
        end else begin
            cnt <= (state == ST_IDLE || st_nx != state) ? '0 : cnt + 1'b1;
            hit <= (state == ST_IDLE) ? '0 : hit_nx;
        end

    // grant and winner's configuration are captured once in IDLE and held for the whole run
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            grant   <= '0;
            dp_a_in <= '0;
            dp_b_in <= '0;
            dp_sel  <= 1'b0;
        end else if (state == ST_IDLE) begin
            grant <= win;
            if (|req) begin
                dp_a_in <= win[1] ? seed_a[7:4] : seed_a[3:0];
                dp_b_in <= win[1] ? seed_b[7:4] : seed_b[3:0];
                dp_sel  <= win[1] ? src_sel[1] : src_sel[0];
            end
        end else if (state == ST_DONE) grant <= '0;

    // status outputs track the next state; results are captured on entry to DONE and held after
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            dp_res  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            aborted <= 1'b0;
            hit_cnt <= '0;
        end else begin
            dp_res <= st_nx != ST_RUN;
            busy   <= st_nx != ST_IDLE;
            done   <= st_nx == ST_DONE;
            if (st_nx == ST_DONE && state != ST_DONE) begin
                hit_cnt <= hit_nx;
                done_id <= grant[1];
                aborted <= abort;
            end
        end
endmodule

// File: doc/prbg_run_ctrl.md
Name: prbg_run_ctrl

Overview:
Controller and arbiter that shares one top_prbg_system pattern-detector datapath between two requesters. It arbitrates between requests round-robin, then loads the winner's seeds and source select into the datapath. It holds the datapath in reset for a fixed load window, runs it for a fixed number of cycles and counts detect pulses. It then reports a per-run result with the requester ID. It sits between software-visible config registers and the PRBG datapath instance.

Parameters:
RUN_LEN, 64, datapath run cycles per grant (>=1)
LOAD_CYC, 2, cycles dp_res held high with seeds applied (>=1)
CNT_W, 8, width of hit counter and run-cycle counter (2^CNT_W > RUN_LEN)

Ports:
clk  input  1  system clock, rising edge
res_n  input  1  asynchronous active-low reset
req  input  2  level request per requester; bit i = requester i
seed_a  input  8  [4i+3:4i] = a_in seed for requester i
seed_b  input  8  [4i+3:4i] = b_in seed for requester i
src_sel  input  2  bit i = datapath sel for requester i
detect_in  input  1  detect_out from datapath
dp_a_in  output  4  seed A to datapath
dp_b_in  output  4  seed B to datapath
dp_sel  output  1  sel to datapath
dp_res  output  1  active-high reset to datapath
grant  output  2  one-hot grant; zero when idle
busy  output  1  high outside IDLE
done  output  1  one-cycle result pulse
done_id  output  1  requester index of last result
aborted  output  1  last run was aborted
hit_cnt  output  CNT_W  detect pulses counted in last run

Behaviour:
- Reset (res_n low, async): state=IDLE; grant=0, busy=0, done=0, done_id=0, aborted=0, hit_cnt=0, dp_a_in=0, dp_b_in=0, dp_sel=0, dp_res=1; rr pointer=1, so requester 0 wins the first tie.
- States: IDLE, LOAD, RUN, DONE. Encoding is binary, 2 bits.
- IDLE: dp_res=1. If any req bit is set, the arbiter picks a winner and the FSM moves to LOAD on the next edge. The winner's seed_a, seed_b and src_sel nibbles/bit are latched into dp_a_in, dp_b_in and dp_sel. grant goes one-hot to the winner.
- Arbitration: if only one request is set, that requester wins. If both are set, the requester not equal to the rr pointer wins. The pointer updates to the winner at grant.
- LOAD: dp_res=1 for exactly LOAD_CYC cycles, then go to RUN. The hit counter and cycle counter are cleared on entry.
- RUN: dp_res=0 for exactly RUN_LEN cycles. Each cycle with detect_in=1 increments the internal hit counter. The counter saturates at 2^CNT_W-1 and does not wrap. detect_in is ignored in every state except RUN.
- Abort: if the granted req bit is low in LOAD or RUN, go to DONE next edge with aborted=1. Hits counted so far are reported.
- Normal completion: after the RUN_LEN-th RUN cycle, go to DONE with aborted=0.
- DONE (1 cycle): done=1; hit_cnt, done_id and aborted are updated in this cycle. dp_res=1, grant is still asserted, and the FSM returns to IDLE next edge.
- Result hold: hit_cnt, done_id and aborted hold until the next DONE.
- Grant timing: grant is high for LOAD_CYC+RUN_LEN+1 cycles on a normal run. Back-to-back runs pass through one IDLE cycle.
- Config changes: seed or src_sel changes after the grant latch have no effect until the next grant.
- Simultaneous events: a detect_in pulse in the last RUN cycle is counted. If the other requester raises req during a run, it waits; it is serviced at the next IDLE.
- Latency: req set in IDLE -> grant/busy next cycle -> dp_res falls LOAD_CYC cycles later.
- All outputs are registered.

Decomposition:
- Package prbg_ctrl_pkg: state encoding constants (ST_IDLE=0, ST_LOAD=1, ST_RUN=2, ST_DONE=3) and default RUN_LEN/LOAD_CYC/CNT_W values.
- Sub-module prbg_rr_arb: 2-way round-robin arbiter (req, pointer, update enable -> one-hot winner). Used at the IDLE->LOAD transition.

Test Plan:
1. Reset check: res_n low mid-RUN -> immediate state=IDLE, grant=0, dp_res=1, hit_cnt=0; then release and req=2'b01 -> grant=01 next cycle.
2. Normal run: req=01, seed_a=8'h0A, seed_b=8'h07, src_sel=0 -> dp_a_in=4'hA, dp_b_in=4'h7, dp_res high 2 cycles then low 64 cycles; done pulse at cycle 67 after grant, done_id=0, aborted=0.
3. Hit counting: force detect_in high on RUN cycles 0, 10 and 63 plus once during LOAD -> hit_cnt=3.
4. Round-robin: req=11 held -> grants alternate 01, 10, 01 with one IDLE cycle between runs; requester 1's seeds (seed_a[7:4]) appear on its run.
5. Abort: req=10 granted, drop req[1] at RUN cycle 5 with 2 hits counted -> DONE next edge, done=1, aborted=1, hit_cnt=2, done_id=1.
6. Saturation: CNT_W=2, RUN_LEN=3... tie detect_in=1 with RUN_LEN=3 -> hit_cnt=3; with override RUN_LEN=3 and CNT_W=2, hit_cnt stays 3 and never wraps.
